// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand request and busy/done/result response of the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a-b one bit per clock, LSB first, with borrow-out
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d, bout_q, bout_d;
    logic             d, bw_n;
    assign d    = a_q[0] ^ b_q[0] ^ bw_q;
    assign bw_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
        end
    end
    // bout_q mirrors the running borrow only while shifting, so the visible result never moves on accept
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = SHIFT;
                a_d     = bus.a;
                b_d     = bus.b;
                bw_d    = 1'b0;
                cnt_d   = '0;
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = {d, r_q[WIDTH-1:1]};
                bw_d    = bw_n;
                bout_d  = bw_n;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.diff = r_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed subtractions scored against plain a-b arithmetic
module tb_serial_subtractor;
    localparam int WIDTH = 8;
    typedef struct {
        logic [WIDTH-1:0] d;
        logic             b;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    exp_t q[$];
    logic [WIDTH-1:0] hold_d;
    logic             hold_b;
    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
    serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        e.d = x - y;
        e.b = (x < y);
        q.push_back(e);
    endtask
    // monitor: scores every done pulse and checks results hold steady outside SHIFT
    always @(negedge clk) begin
        if (rst) begin
            hold_d = '0;
            hold_b = 1'b0;
        end else if (bus.done) begin
            check("busy_during_done", bus.busy, 0);
            if (q.size() == 0) check("unexpected_done", q.size(), 1);
            else begin
                exp_t e;
                e = q.pop_front();
                check("diff", bus.diff, e.d);
                check("bout", bus.bout, e.b);
                hold_d = e.d;
                hold_b = e.b;
            end
        end else if (!bus.busy) begin
            check("diff_hold", bus.diff, hold_d);
            check("bout_hold", bus.bout, hold_b);
        end
    end
    task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit disturb);
        int n, nb;
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        push(x, y);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        n = 1;
        nb = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) nb++;
            if (disturb && n == 3) begin
                bus.start = 1'b1;
                bus.a = 8'hAA;
                bus.b = 8'h55;
            end else bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        check("latency_edges", n, WIDTH + 1);
        check("busy_cycles", nb, WIDTH);
        @(posedge clk); #1;
    endtask
    task automatic back_to_back();
        int dt[$];
        logic [WIDTH-1:0] x, y;
        x = 8'h5A; y = 8'hC3;
        bus.start = 1'b1;
        bus.a = x; bus.b = y;
        push(x, y);
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (bus.done) dt.push_back(c);
            if (c == 1 || c == 11) begin
                x = WIDTH'($urandom);
                y = WIDTH'($urandom);
                bus.a = x; bus.b = y;
                push(x, y);
            end
            if (c == 21) bus.start = 1'b0;
        end
        check("b2b_done_count", dt.size(), 3);
        if (dt.size() == 3) begin
            check("b2b_gap1", dt[1] - dt[0], WIDTH + 2);
            check("b2b_gap2", dt[2] - dt[1], WIDTH + 2);
        end
    endtask
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(8'h05, 8'h03, 1'b0);
        run(8'h03, 8'h05, 1'b0);
        run(8'h00, 8'h01, 1'b0);
        run(8'hFF, 8'hFF, 1'b0);
        run(8'h10, 8'h01, 1'b1);
        // abandon an operation four bits in; partial diff is nonzero at that point
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        q.delete();
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_diff", bus.diff, 0);
        check("arst_bout", bus.bout, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        run(8'h80, 8'h01, 1'b0);
        back_to_back();
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : WIDTH'($urandom);
            y = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hFF : x) : WIDTH'($urandom);
            run(x, y, i[4]);
        end
        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while bits are being processed (state SHIFT).
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-009 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  final borrow; 1 when a < b (unsigned).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE; all outputs registered.
REQ-012 IDLE: start=1 on a rising edge -> load a and b into internal shift registers, clear borrow, clear bit counter, go to SHIFT.
REQ-013 IDLE: start=0 -> remain in IDLE; diff and bout hold their last values.
REQ-014 SHIFT: each rising edge processes one bit, LSB first: d = a0 XOR b0 XOR bw; bw_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND bw).
REQ-015 SHIFT: on each edge, operand registers shift right by one, d enters the result register at the MSB end, and the counter increments.
REQ-016 SHIFT: on the edge that processes bit WIDTH-1 -> go to DONE; diff holds the full result and bout the final borrow from that edge onward.
REQ-017 DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-018 Latency: done SHALL be high during the cycle after the (WIDTH+1)th rising edge counted from and including the edge that accepts start; WIDTH=8 gives 9 edges.
REQ-019 busy SHALL be 1 in SHIFT only; busy and done SHALL never be 1 in the same cycle.
REQ-020 start in SHIFT or DONE SHALL be ignored; changes on a/b after acceptance SHALL not affect the result.
REQ-021 start held high continuously SHALL start a new operation on the first edge spent in IDLE after DONE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 diff and bout SHALL change only during SHIFT and SHALL stay stable from done until the next accepted start.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; bout equals the bit-serial borrow-out; no overflow flag.

Reset
REQ-024 rst=1 SHALL force, asynchronously: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow=0, operand registers=0.
REQ-025 rst asserted mid-SHIFT or during DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x05, b=0x03, start pulse -> busy high for 8 cycles, then done pulse with diff=0x02, bout=0.
REQ-028 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0xFF, b=0xFF -> diff=0x00, bout=0.
REQ-029 Start accepted with a=0x10, b=0x01; then a=0xAA, b=0x55 with start pulsed during SHIFT -> ignored; diff=0x0F, bout=0, exactly one done.
REQ-030 rst asserted 4 cycles into SHIFT -> outputs read 0 immediately, no done; next operation a=0x80, b=0x01 -> diff=0x7F, bout=0.
REQ-031 start held high for 3 operations -> done pulses exactly 10 cycles apart, each result correct.
REQ-032 All 65536 (a,b) pairs -> compare against reference model: diff=(a-b) mod 256, bout=(a<b); zero mismatches.
